pong_frame_sequencer: RTL



---
 rtl/pong_frame_sequencer_if.sv | 10 +
 rtl/pong_frame_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_sequencer_if.sv
// Pixel-write bus between the frame sequencer (master) and the VGA adapter (slave).
interface pong_frame_sequencer_if;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] colour;
  logic       plot;

  modport master (output vgaX, vgaY, colour, plot);
  modport slave  (input  vgaX, vgaY, colour, plot);
endinterface

// File: rtl/pong_frame_sequencer.sv
// pong_frame_sequencer: per-frame controller for the Pong display path.
// Each frame erases the ball neighbourhood, strobes the game logic, redraws
// the ball and (optionally) redraws the paddle column through the single
// pixel-write port of the VGA adapter.
// Optional feature macro: PONG_PADDLE_DRAW_EN (defined -> paddle column is
// redrawn each frame; undefined -> frame ends after the ball, paddleY unused).
module pong_frame_sequencer #(
  parameter logic [7:0] ERASE_X_HI   = 8'd129,
  parameter logic [7:0] ERASE_X_LO   = 8'd14,
  parameter logic [6:0] ERASE_HALF_H = 7'd5,
  parameter logic [7:0] BALL_SIZE    = 8'd3,
  parameter logic [7:0] PADDLE_X     = 8'd10,
  parameter logic [7:0] PADDLE_H     = 8'd20,
  parameter logic [2:0] BG_COLOUR    = 3'b000,
  parameter logic [2:0] FG_COLOUR    = 3'b111
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [7:0]             ballX,
  input  logic [6:0]             ballY,
  input  logic [6:0]             paddleY,
  pong_frame_sequencer_if.master vga,
  output logic                   update,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic [2:0] {
    S_WAIT_TICK,
    S_ERASE,
    S_UPDATE,
    S_SETTLE,
    S_DRAW_BALL,
    S_DRAW_PADDLE
  } state_t;

  localparam logic [6:0] PADDLE_LAST_Y = 7'd119;

  state_t     r_state;
  logic       r_pending;
  logic [7:0] r_vgaX;
  logic [6:0] r_vgaY;
  logic [2:0] r_colour;
  logic       r_plot;
  logic       r_update;
  logic       r_busy;
  logic       r_overrun;

  // Snapshot of the game state, only sampled at the two frame snapshot points.
  logic [7:0] r_ballX_s;
  logic [6:0] r_ballY_s;

  // Scan counters: r_cx/r_cy walk the erase window and the paddle rows,
  // r_ox/r_oy are offsets inside the ball square (r_ox also picks paddle column).
  logic [7:0] r_cx;
  logic [6:0] r_cy;
  logic [7:0] r_ox;
  logic [6:0] r_oy;

  logic [6:0] w_erase_y0;
  logic [6:0] w_erase_last_y;
  logic [7:0] w_ball_x;
  logic [6:0] w_ball_y;
  logic       w_ball_row_end;
  logic       w_ball_last;

  // Row arithmetic wraps modulo 128, column arithmetic modulo 256.
  assign w_erase_y0     = ballY - ERASE_HALF_H;
  assign w_erase_last_y = r_ballY_s + ERASE_HALF_H;
  assign w_ball_x       = r_ballX_s + r_ox;
  assign w_ball_y       = r_ballY_s + r_oy;
  assign w_ball_row_end = (r_ox == BALL_SIZE - 8'd1);
  assign w_ball_last    = w_ball_row_end && (r_oy == 7'(BALL_SIZE - 8'd1));

`ifdef PONG_PADDLE_DRAW_EN
  logic [6:0] r_paddleY_s;
  logic [7:0] w_pad_lo;
  logic [7:0] w_pad_hi;
  logic [7:0] w_pad_row;
  logic       w_pad_fg;

  // 8-bit compare so paddleY + PADDLE_H may exceed 127 without wrapping.
  assign w_pad_lo  = {1'b0, r_paddleY_s};
  assign w_pad_hi  = w_pad_lo + PADDLE_H;
  assign w_pad_row = {1'b0, r_cy};
  assign w_pad_fg  = (w_pad_row >= w_pad_lo) && (w_pad_row < w_pad_hi);
`else
  logic w_unused_paddleY;
  assign w_unused_paddleY = ^paddleY;
`endif

  // Frame FSM: sequences the draw phases and registers every output.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= S_WAIT_TICK;
      r_pending <= 1'b0;
      r_vgaX    <= 8'd0;
      r_vgaY    <= 7'd0;
      r_colour  <= 3'd0;
      r_plot    <= 1'b0;
      r_update  <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_plot    <= 1'b0;
      r_update  <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= (r_state != S_WAIT_TICK);

      // A tick arriving mid-frame is remembered once; a second one is dropped.
      if ((r_state != S_WAIT_TICK) && frame_tick) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end

      case (r_state)
        S_WAIT_TICK: begin
          if (frame_tick || r_pending) begin
            // A fresh tick coinciding with a pending start cannot be queued.
            r_overrun <= frame_tick & r_pending;
            r_pending <= 1'b0;
            r_ballX_s <= ballX;
            r_ballY_s <= ballY;
`ifdef PONG_PADDLE_DRAW_EN
            r_paddleY_s <= paddleY;
`endif
            r_cx      <= ERASE_X_HI;
            r_cy      <= w_erase_y0;
            r_state   <= S_ERASE;
          end
        end

        S_ERASE: begin
          r_plot   <= 1'b1;
          r_vgaX   <= r_cx;
          r_vgaY   <= r_cy;
          r_colour <= BG_COLOUR;
          if (r_cx == ERASE_X_LO) begin
            r_cx <= ERASE_X_HI;
            r_cy <= r_cy + 7'd1;
            if (r_cy == w_erase_last_y) r_state <= S_UPDATE;
          end else begin
            r_cx <= r_cx - 8'd1;
          end
        end

        S_UPDATE: begin
          r_update <= 1'b1;
          r_state  <= S_SETTLE;
        end

        S_SETTLE: begin
          r_ballX_s <= ballX;
          r_ballY_s <= ballY;
`ifdef PONG_PADDLE_DRAW_EN
          r_paddleY_s <= paddleY;
`endif
          r_ox      <= 8'd0;
          r_oy      <= 7'd0;
          r_state   <= S_DRAW_BALL;
        end

        S_DRAW_BALL: begin
          r_plot   <= 1'b1;
          r_vgaX   <= w_ball_x;
          r_vgaY   <= w_ball_y;
          r_colour <= FG_COLOUR;
          if (w_ball_row_end) begin
            r_ox <= 8'd0;
            r_oy <= r_oy + 7'd1;
          end else begin
            r_ox <= r_ox + 8'd1;
          end
          if (w_ball_last) begin
`ifdef PONG_PADDLE_DRAW_EN
            r_ox    <= 8'd0;
            r_cy    <= 7'd0;
            r_state <= S_DRAW_PADDLE;
`else
            r_state <= S_WAIT_TICK;
`endif
          end
        end

`ifdef PONG_PADDLE_DRAW_EN
        S_DRAW_PADDLE: begin
          r_plot   <= 1'b1;
          r_vgaX   <= PADDLE_X + r_ox;
          r_vgaY   <= r_cy;
          r_colour <= w_pad_fg ? FG_COLOUR : BG_COLOUR;
          if (r_ox == 8'd1) begin
            r_ox <= 8'd0;
            r_cy <= r_cy + 7'd1;
            if (r_cy == PADDLE_LAST_Y) r_state <= S_WAIT_TICK;
          end else begin
            r_ox <= r_ox + 8'd1;
          end
        end
`endif

        default: r_state <= S_WAIT_TICK;
      endcase
    end
  end

  assign vga.vgaX   = r_vgaX;
  assign vga.vgaY   = r_vgaY;
  assign vga.colour = r_colour;
  assign vga.plot   = r_plot;
  assign update     = r_update;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule
